pll_phase_stepper: RTL and testbench
====================================

// Module: pll_phase_stepper
// PURPOSE
//  Runtime phase-shift sequencer for the dynamic phase port of the on-chip PLL (PHASESEL/PHASEDIR/PHASESTEP).
//  Accepts "step channel C by N positions, lead or lag" requests from the glitch controller.
//  Emits correctly timed step pulses with settle gaps, so glitch edges can be placed in sub-cycle increments.
//  Sits between the control/UART register file and the PLL wrapper; runs in the system clock domain.
// PARAMETERS
//  NUM_CH      4    PLL output channels addressable (1..4; channel index drives phase_sel)
//  STEP_W      8    width of per-request step count (max 2^STEP_W-1 steps)
//  PULSE_CYC   2    phase_step high time per step, clk cycles (>=1)
//  SETTLE_CYC  4    idle gap after each pulse before next pulse/done, clk cycles (>=1)
//  PHASE_MOD   384  phase positions per output-clock period (position wrap modulus)
// PORTS
//  clk        in   1           system clock
//  rst_n      in   1           asynchronous reset, active low
//  req_valid  in   1           request present
//  req_ready  out  1           block idle, request accepted when valid&ready
//  req_ch     in   2           target channel
//  req_dir    in   1           0 = lead (+1 per step), 1 = lag (-1 per step)
//  req_steps  in   STEP_W      number of steps
//  busy       out  1           high from cycle after accept until return to IDLE
//  done       out  1           one-cycle pulse, request finished
//  err        out  1           valid with done: 1 = req_ch >= NUM_CH, no pulses issued
//  phase_sel  out  2           to PLL PHASESEL
//  phase_dir  out  1           to PLL PHASEDIR
//  phase_step out  1           to PLL PHASESTEP (idle low, high pulse per step)
//  rd_ch      in   2           position readback channel select
//  rd_pos     out  $clog2(PHASE_MOD)  registered position of rd_ch, 1-cycle latency
// BEHAVIOUR
//  Reset: busy=0, done=0, err=0, req_ready=1, phase_sel=0, phase_dir=0, phase_step=0, rd_pos=0, all positions=0.
//  Reset mid-operation: phase_step drops to 0 asynchronously; the sequence is abandoned and not resumed.
//  FSM: IDLE -> SETUP (1 cyc) -> PULSE (PULSE_CYC) -> SETTLE (SETTLE_CYC) -> PULSE... -> DONE (1 cyc) -> IDLE.
//  IDLE: req_ready=1.
//   - On valid&ready, latch ch/dir/steps into internal registers; req_* are don't-care afterwards.
//  SETUP: phase_sel/phase_dir driven from the latched values; they stay stable through the last SETTLE.
//  PULSE: phase_step=1. On entry, remaining is decremented and the channel position is updated.
//  SETTLE: phase_step=0. On exit, go to PULSE if remaining!=0, otherwise DONE.
//  DONE: done=1 and busy=1 for this cycle; req_ready=1 again the next cycle. No back-to-back accept.
//  Timing: accept at edge E; busy for 2+N*(PULSE_CYC+SETTLE_CYC) cycles; done is the last of these.
//  steps==0: SETUP -> DONE directly (2 busy cycles), no pulse, err=0.
//  req_ch>=NUM_CH: SETUP -> DONE, err=1 with done, no pulse, no position change.
//  req_valid while busy: ignored (ready=0); the requester holds it.
//  Position arithmetic is modulo PHASE_MOD:
//   - lead: PHASE_MOD-1 -> 0
//   - lag: 0 -> PHASE_MOD-1
//  rd_pos: registered each cycle from pos[rd_ch]. rd_ch>=NUM_CH reads 0.
//   - Reading the channel being stepped returns the value updated at PULSE entry, one cycle later.
// CONFIGURATION
//  PLL_PHASE_TRACK_EN defined: per-channel position registers are kept, and rd_pos is live as above.
//  Not defined: no position storage; rd_pos is constant 0; stepping behaviour and timing are identical.
// STRUCTURE
//  pll_phase_pkg:
//   - FSM state encoding (IDLE, SETUP, PULSE, SETTLE, DONE)
//   - DIR_LEAD=0 and DIR_LAG=1
//   - pos_wrap helper function (+/-1 modulo PHASE_MOD)
//  Sub-module pll_phase_pos_track:
//   - NUM_CH position registers, update strobe, and registered read port
//   - instantiated only under PLL_PHASE_TRACK_EN
//  Top holds the FSM, pulse/settle counter ($clog2(max(PULSE_CYC,SETTLE_CYC))) and remaining-steps counter.
// TESTING
//  Defaults, ch=1, dir=0, steps=3: exactly 3 phase_step pulses, each 2 cyc high with 4-cyc gaps.
//   - phase_sel=1 stable throughout; done on busy cycle 20; rd_pos(ch1)=3.
//  ch=1, dir=1, steps=5 from pos 3: wraps to 382; rd_pos=382 (PHASE_MOD=384).
//  ch=0, steps=0: no pulse, done 2 cycles after accept, err=0.
//  ch=3 with NUM_CH=2, steps=4: no pulse, done with err=1; all positions unchanged.
//  req_valid held during busy with new values: not accepted until ready.
//   - Second request executes from the post-done IDLE with its own values.
//  rst_n low during 2nd PULSE: phase_step=0 immediately; after release, IDLE with all outputs at reset values.
//   - Repeat the test without PLL_PHASE_TRACK_EN: identical pulse timing, rd_pos=0.

Source files
------------

// File: rtl/pll_phase_pkg.sv
// Shared types for the PLL phase stepper: FSM states, step direction codes, position wrap helper.
// Purely combinational definitions; no latency or backpressure of its own.
package pll_phase_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  localparam logic DIR_LEAD = 1'b0;
  localparam logic DIR_LAG  = 1'b1;

  // One phase position forward (lead) or back (lag), wrapping at modulus.
  function automatic logic [15:0] pos_wrap(input logic [15:0] pos, input logic dir,
                                           input logic [15:0] modulus);
    if (dir == DIR_LAG) begin
      return (pos == 16'd0) ? modulus - 16'd1 : pos - 16'd1;
    end
    return (pos == modulus - 16'd1) ? 16'd0 : pos + 16'd1;
  endfunction

endpackage

// File: rtl/pll_phase_pos_track.sv
// Per-channel phase position registers (used only with PLL_PHASE_TRACK_EN), updated on a strobe.
// Read port is registered: rd_pos_o follows rd_ch_i one cycle later; no backpressure.
module pll_phase_pos_track
  import pll_phase_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int PHASE_MOD = 384,
  parameter int POS_W     = $clog2(PHASE_MOD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_vld_i,
  input  logic [1:0]       upd_ch_i,
  input  logic             upd_dir_i,
  input  logic [1:0]       rd_ch_i,
  output logic [POS_W-1:0] rd_pos_o
);

  logic [POS_W-1:0] pos_q [NUM_CH];
  logic [POS_W-1:0] rd_pos_q;
  logic [POS_W-1:0] rd_pos_d;

  // Channels outside NUM_CH match no entry and read back as zero.
  always_comb begin
    rd_pos_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch_i == 2'(i)) rd_pos_d = pos_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) pos_q[i] <= '0;
      rd_pos_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (upd_vld_i && upd_ch_i == 2'(i)) begin
          pos_q[i] <= POS_W'(pos_wrap(16'(pos_q[i]), upd_dir_i, 16'(PHASE_MOD)));
        end
      end
      rd_pos_q <= rd_pos_d;
    end
  end

  assign rd_pos_o = rd_pos_q;

endmodule

// File: rtl/pll_phase_stepper.sv
// Drives PLL PHASESEL/PHASEDIR/PHASESTEP pulses with settle gaps; position readback under PLL_PHASE_TRACK_EN.
// Busy 2+N*(PULSE_CYC+SETTLE_CYC) cycles per request; req_ready low while busy, requester holds req_valid.
module pll_phase_stepper
  import pll_phase_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int STEP_W     = 8,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 4,
  parameter int PHASE_MOD  = 384
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_ch,
  input  logic                         req_dir,
  input  logic [STEP_W-1:0]            req_steps,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [1:0]                   phase_sel,
  output logic                         phase_dir,
  output logic                         phase_step,
  input  logic [1:0]                   rd_ch,
  output logic [$clog2(PHASE_MOD)-1:0] rd_pos
);

  localparam int MAX_CYC = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STEP_W-1:0]   rem_q;
  logic [1:0]          ch_q;
  logic                dir_q;
  logic                err_q;
  logic                step_q;
  logic                accept;
  logic                pulse_entry;

  assign req_ready   = (state_q == ST_IDLE);
  assign accept      = req_valid && req_ready;
  assign pulse_entry = (state_d == ST_PULSE) && (state_q != ST_PULSE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: begin
        if (err_q || rem_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LD;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rem_q != '0) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // phase_step is a flop so the PLL sees a clean pulse; async reset drops it immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      ch_q    <= '0;
      dir_q   <= DIR_LEAD;
      err_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= (state_d == ST_PULSE);
      if (accept) begin
        ch_q  <= req_ch;
        dir_q <= req_dir;
        rem_q <= req_steps;
        err_q <= (int'(req_ch) >= NUM_CH);
      end else if (pulse_entry) begin
        rem_q <= rem_q - STEP_W'(1);
      end
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err        = done && err_q;
  assign phase_sel  = ch_q;
  assign phase_dir  = dir_q;
  assign phase_step = step_q;

`ifdef PLL_PHASE_TRACK_EN
  pll_phase_pos_track #(
    .NUM_CH    (NUM_CH),
    .PHASE_MOD (PHASE_MOD),
    .POS_W     ($clog2(PHASE_MOD))
  ) u_pos_track (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd_vld_i (pulse_entry),
    .upd_ch_i  (ch_q),
    .upd_dir_i (dir_q),
    .rd_ch_i   (rd_ch),
    .rd_pos_o  (rd_pos)
  );
`else
  logic unused_rd_ch;
  assign unused_rd_ch = ^rd_ch;
  assign rd_pos       = '0;
`endif

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Self-checking bench for pll_phase_stepper: vector table, hand sequences, randomized requests vs a timing/position model.
module tb_pll_phase_stepper;

  localparam int NUM_CH_T = 2;
  localparam int P        = 2;
  localparam int S        = 4;
  localparam int MOD      = 384;
`ifdef PLL_PHASE_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_ch = 2'd0;
  logic       req_dir = 1'b0;
  logic [7:0] req_steps = 8'd0;
  logic       busy, done, err;
  logic [1:0] phase_sel;
  logic       phase_dir, phase_step;
  logic [1:0] rd_ch = 2'd0;
  logic [8:0] rd_pos;

  int checks = 0;
  int errors = 0;
  int mpos[4];

  always #5 clk = ~clk;

  pll_phase_stepper #(
    .NUM_CH(NUM_CH_T), .STEP_W(8), .PULSE_CYC(P), .SETTLE_CYC(S), .PHASE_MOD(MOD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_ch(req_ch), .req_dir(req_dir),
    .req_steps(req_steps), .busy(busy), .done(done), .err(err),
    .phase_sel(phase_sel), .phase_dir(phase_dir), .phase_step(phase_step),
    .rd_ch(rd_ch), .rd_pos(rd_pos)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wrapm(input int v);
    return ((v % MOD) + MOD) % MOD;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_step"}, phase_step, 0);
  endtask

  // One request checked cycle by cycle against the expected busy window and pulse train.
  task automatic run_req(input logic [1:0] ch, input logic dir, input int steps,
                         input bit hold, input logic [1:0] nch, input logic ndir, input int nsteps,
                         output int done_at, output int waited);
    bit is_err;
    int total, start, sgn;
    is_err  = (int'(ch) >= NUM_CH_T);
    total   = (is_err || steps == 0) ? 2 : 2 + steps * (P + S);
    start   = is_err ? 0 : mpos[ch];
    sgn     = dir ? -1 : 1;
    done_at = 0;
    waited  = 0;
    req_ch = ch; req_dir = dir; req_steps = 8'(steps); req_valid = 1'b1; rd_ch = ch;
    while (!req_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      req_ch = nch; req_dir = ndir; req_steps = 8'(nsteps);
    end else begin
      req_valid = 1'b0;
      req_ch = 2'($urandom); req_dir = 1'($urandom); req_steps = 8'($urandom);
    end
    for (int k = 1; k <= total; k++) begin
      int nd;
      if (k > 1) @(negedge clk);
      if (done && done_at == 0) done_at = k;
      chk("busy", busy, 1);
      chk("ready_low", req_ready, 0);
      chk("done", done, int'(k == total));
      chk("err", err, int'((k == total) && is_err));
      chk("phase_step", phase_step, int'(k >= 2 && k < total && ((k - 2) % (P + S)) < P));
      chk("phase_sel", phase_sel, ch);
      chk("phase_dir", phase_dir, dir);
      nd = (is_err || k < 3) ? 0 : ((k - 3) / (P + S) + 1);
      if (nd > steps) nd = steps;
      chk("rd_pos_live", rd_pos, TRACK ? wrapm(start + sgn * nd) : 0);
    end
    @(negedge clk);
    chk_idle_outputs("post_done");
    if (!is_err) mpos[ch] = wrapm(start + sgn * steps);
  endtask

  task automatic rd_check(input string name, input logic [1:0] ch, input int exp);
    rd_ch = ch;
    @(negedge clk);
    chk(name, rd_pos, TRACK ? exp : 0);
  endtask

  typedef struct {
    logic [1:0] ch;
    logic       dir;
    int         steps;
    int         exp_done;
    int         exp_pos;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int da, w;
    tbl[0] = '{2'd1, 1'b0, 3, 20, 3};
    tbl[1] = '{2'd1, 1'b1, 5, 32, 382};
    tbl[2] = '{2'd0, 1'b0, 0, 2, 0};
    tbl[3] = '{2'd3, 1'b0, 4, 2, 0};
    tbl[4] = '{2'd0, 1'b1, 1, 8, 383};
    tbl[5] = '{2'd0, 1'b0, 2, 14, 1};
    for (int i = 0; i < 4; i++) mpos[i] = 0;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_sel", phase_sel, 0);
    chk("rst_dir", phase_dir, 0);
    chk("rst_step", phase_step, 0);
    chk("rst_rd_pos", rd_pos, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_req(tbl[i].ch, tbl[i].dir, tbl[i].steps, 1'b0, 2'd0, 1'b0, 0, da, w);
      chk($sformatf("tbl%0d_done_at", i), da, tbl[i].exp_done);
      chk($sformatf("tbl%0d_rd_pos", i), rd_pos, TRACK ? tbl[i].exp_pos : 0);
    end
    rd_check("err_req_ch1_kept", 2'd1, 382);
    rd_check("err_req_ch0_kept", 2'd0, 1);
    rd_check("rd_out_of_range", 2'd3, 0);

    // Request held during busy with new values: ignored, then executed right after done.
    run_req(2'd0, 1'b0, 1, 1'b1, 2'd1, 1'b1, 2, da, w);
    run_req(2'd1, 1'b1, 2, 1'b0, 2'd0, 1'b0, 0, da, w);
    chk("held_req_wait", w, 0);
    chk("held_req_done_at", da, 14);
    rd_check("held_req_pos", 2'd1, 380);

    // Reset asserted during the second pulse.
    req_ch = 2'd1; req_dir = 1'b0; req_steps = 8'd3; req_valid = 1'b1; rd_ch = 2'd1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("pulse2_high", phase_step, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_step_drop", phase_step, 0);
    chk("async_busy_drop", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mpos[i] = 0;
    @(negedge clk);
    chk("rel_ready", req_ready, 1);
    chk("rel_sel", phase_sel, 0);
    chk("rel_dir", phase_dir, 0);
    chk("rel_err", err, 0);
    chk("rel_rd_pos", rd_pos, 0);
    for (int i = 0; i < 10; i++) begin
      chk_idle_outputs("no_resume");
      @(negedge clk);
    end

    for (int i = 0; i < 12; i++) begin
      run_req(2'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 12)),
              1'b0, 2'd0, 1'b0, 0, da, w);
    end
    for (int c = 0; c < 4; c++) begin
      rd_check($sformatf("final_pos_ch%0d", c), 2'(c), (c < NUM_CH_T) ? mpos[c] : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "bench timeout");
  end

endmodule
